// File: rtl/aes_kat_sequencer.sv
// ---------------------------------------------------------------------------
// aes_kat_sequencer
//
// Known-answer-test sequencer for the AES demo. It drives the AES core with
// the FIPS-197 vectors for AES-128/192/256 (or sweeps all three), runs a
// start/done handshake with a timeout, checks each ciphertext, and reports
// the result on flags and a seven-segment word display.
//
// Parameters
//   TIMEOUT_CYCLES : max WAIT cycles per vector before a timeout (>= 2)
//   DISP_DIGITS    : seven-segment digits driven (>= 3), 7 bits per digit
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   mode[1:0]   in   0 sweep, 1 AES-128, 2 AES-192, 3 AES-256 (sampled on start)
//   start       in   single-cycle run request (accepted in IDLE/DONE only)
//   core_start  out  one-cycle launch pulse to the AES core
//   core_nr     out  round count 10/12/14
//   core_key    out  key, left-aligned in 256 bits
//   core_in     out  plaintext
//   core_done   in   core result valid (only looked at in WAIT)
//   core_out    in   core ciphertext
//   busy        out  high outside IDLE/DONE
//   flag        out  all vectors of the run passed
//   fail        out  mismatch or timeout
//   timeout     out  failure was a timeout
//   pass_count  out  vectors passed this run
//   sevenSeg    out  active-low {g,f,e,d,c,b,a} per digit, digit 0 in LSBs
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// LOAD  | vector presented to the core, core_start high this cycle
// WAIT  | waiting for core_done, counting toward the timeout
// CHECK | captured ciphertext compared against the ROM
// DONE  | results held until the next accepted start
module aes_kat_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DISP_DIGITS    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     start,
    output logic                     core_start,
    output logic [3:0]               core_nr,
    output logic [255:0]             core_key,
    output logic [127:0]             core_in,
    input  logic                     core_done,
    input  logic [127:0]             core_out,
    output logic                     busy,
    output logic                     flag,
    output logic                     fail,
    output logic                     timeout,
    output logic [1:0]               pass_count,
    output logic [7*DISP_DIGITS-1:0] sevenSeg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = 7 * DISP_DIGITS;

    localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_I     = 7'h79;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    function automatic logic [3:0] rom_nr(input logic [1:0] i);
        case (i)
            2'd0:    rom_nr = 4'd10;
            2'd1:    rom_nr = 4'd12;
            default: rom_nr = 4'd14;
        endcase
    endfunction

    function automatic logic [255:0] rom_key(input logic [1:0] i);
        case (i)
            2'd0:    rom_key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
            2'd1:    rom_key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
            default: rom_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        endcase
    endfunction

    function automatic logic [127:0] rom_ct(input logic [1:0] i);
        case (i)
            2'd0:    rom_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            2'd1:    rom_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            default: rom_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [127:0]   res_q, res_d;
    logic           core_start_q, core_start_d;
    logic [3:0]     nr_q, nr_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   in_q, in_d;
    logic           busy_q, busy_d;
    logic           flag_q, flag_d;
    logic           fail_q, fail_d;
    logic           timeout_q, timeout_d;
    logic [1:0]     pass_q, pass_d;
    logic [SW-1:0]  seg_q, seg_d;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        core_start_d = 1'b0;
        nr_d         = nr_q;
        key_d        = key_q;
        in_d         = in_q;
        flag_d       = flag_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        pass_d       = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d    = mode;
                    idx_d     = (mode == 2'd0) ? 2'd0 : mode - 2'd1;
                    flag_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    pass_d    = 2'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the limit cycle still wins over the timeout.
                if (core_done) begin
                    res_d   = core_out;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_CHECK: begin
                if (res_q == rom_ct(idx_q)) begin
                    pass_d = pass_q + 2'd1;
                    if (mode_q == 2'd0 && idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_LOAD;
                    end else begin
                        flag_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Vector registers are loaded on the edge into LOAD so they are
        // valid together with the core_start pulse and held afterwards.
        if (state_d == S_LOAD) begin
            core_start_d = 1'b1;
            nr_d         = rom_nr(idx_d);
            key_d        = rom_key(idx_d);
            in_d         = PLAINTEXT;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

        for (int i = 0; i < DISP_DIGITS; i++) begin
            seg_d[7*i +: 7] = SEG_BLANK;
        end
        if (busy_d) begin
            seg_d[SW-7 +: 7]  = SEG_DASH;
            seg_d[SW-14 +: 7] = SEG_DASH;
            seg_d[SW-21 +: 7] = SEG_DASH;
        end else if (state_d == S_DONE && fail_d) begin
            seg_d[SW-7 +: 7]  = SEG_F;
            seg_d[SW-14 +: 7] = SEG_A;
            seg_d[SW-21 +: 7] = SEG_I;
        end else if (state_d == S_DONE && flag_d) begin
            seg_d[SW-7 +: 7]  = SEG_P;
            seg_d[SW-14 +: 7] = SEG_A;
            seg_d[SW-21 +: 7] = SEG_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mode_q       <= 2'd0;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            res_q        <= 128'h0;
            core_start_q <= 1'b0;
            nr_q         <= 4'd0;
            key_q        <= 256'h0;
            in_q         <= 128'h0;
            busy_q       <= 1'b0;
            flag_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            pass_q       <= 2'd0;
            seg_q        <= {SW{1'b1}};
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            core_start_q <= core_start_d;
            nr_q         <= nr_d;
            key_q        <= key_d;
            in_q         <= in_d;
            busy_q       <= busy_d;
            flag_q       <= flag_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            pass_q       <= pass_d;
            seg_q        <= seg_d;
        end
    end

    assign core_start = core_start_q;
    assign core_nr    = nr_q;
    assign core_key   = key_q;
    assign core_in    = in_q;
    assign busy       = busy_q;
    assign flag       = flag_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign pass_count = pass_q;
    assign sevenSeg   = seg_q;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
module tb_aes_kat_sequencer;

    localparam int TO = 64;
    localparam int DD = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     mode;
    logic           start;
    logic           core_start;
    logic [3:0]     core_nr;
    logic [255:0]   core_key;
    logic [127:0]   core_in;
    logic           core_done;
    logic [127:0]   core_out;
    logic           busy, flag, fail, timeout;
    logic [1:0]     pass_count;
    logic [7*DD-1:0] sevenSeg;

    always #5 clk = ~clk;

    aes_kat_sequencer #(.TIMEOUT_CYCLES(TO), .DISP_DIGITS(DD)) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start),
        .core_start(core_start), .core_nr(core_nr), .core_key(core_key),
        .core_in(core_in), .core_done(core_done), .core_out(core_out),
        .busy(busy), .flag(flag), .fail(fail), .timeout(timeout),
        .pass_count(pass_count), .sevenSeg(sevenSeg)
    );

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    logic [3:0]   nr_tab  [3];
    logic [255:0] key_tab [3];
    logic [127:0] ct_tab  [3];

    typedef struct {
        logic [1:0] mode;
        int         delay;      // cycles from core_start to core_done; 0 = never
        int         bad_idx;    // vector whose result gets a flipped bit; 3 = none
        int         exp_starts;
        int         exp_done;   // cycle (after start edge) where busy is first low
        logic       exp_flag;
        logic       exp_fail;
        logic       exp_to;
        logic [1:0] exp_pass;
        string      name;
    } vec_t;

    vec_t vecs [8];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_core_start"}, 256'(core_start), 256'(0));
        chk({tag, "_nr"},         256'(core_nr), 256'(0));
        chk({tag, "_key"},        core_key, 256'(0));
        chk({tag, "_in"},         256'(core_in), 256'(0));
        chk({tag, "_busy"},       256'(busy), 256'(0));
        chk({tag, "_flag"},       256'(flag), 256'(0));
        chk({tag, "_fail"},       256'(fail), 256'(0));
        chk({tag, "_timeout"},    256'(timeout), 256'(0));
        chk({tag, "_pass"},       256'(pass_count), 256'(0));
        chk({tag, "_seg"},        256'(sevenSeg), 256'(21'h1FFFFF));
    endtask

    function automatic int nr_to_idx(input logic [3:0] nr);
        if (nr == 4'd10) return 0;
        if (nr == 4'd12) return 1;
        return 2;
    endfunction

    // Start a run and act as the AES core; noise pokes start/mode while busy.
    task automatic run_vec(input vec_t v, input bit noise);
        int starts, done_at, done_cyc, ei, ri;
        logic [20:0] exp_seg;
        starts = 0; done_at = -1; done_cyc = -1;
        ei = (v.mode == 2'd0) ? 0 : int'(v.mode) - 1;
        @(negedge clk);
        mode = v.mode;
        start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            core_done = 1'b0;
            if (noise && cyc == 3) begin start = 1'b1; mode = 2'd3; end
            if (noise && cyc == 4) mode = 2'd0;
            if (cyc == 1) chk({v.name, "_busy_c1"}, 256'(busy), 256'(1));
            if (core_start) begin
                starts++;
                if (ei <= 2) begin
                    chk($sformatf("%s_nr%0d", v.name, starts), 256'(core_nr), 256'(nr_tab[ei]));
                    chk($sformatf("%s_key%0d", v.name, starts), core_key, key_tab[ei]);
                    chk($sformatf("%s_in%0d", v.name, starts), 256'(core_in), 256'(PT));
                end
                ei++;
                if (v.delay > 0) done_at = cyc + v.delay;
            end
            if (cyc == done_at) begin
                core_done = 1'b1;
                ri = nr_to_idx(core_nr);
                core_out = ct_tab[ri] ^ ((ri == v.bad_idx) ? 128'h1 : 128'h0);
            end
            if (cyc > 1 && !busy) begin
                done_cyc = cyc;
                break;
            end
        end
        core_done = 1'b0;
        if (done_cyc < 0) $display("FAIL %s_bound: busy never dropped within 200 cycles", v.name);
        chk({v.name, "_done_cycle"}, 256'(done_cyc), 256'(v.exp_done));
        chk({v.name, "_starts"},  256'(starts), 256'(v.exp_starts));
        chk({v.name, "_flag"},    256'(flag), 256'(v.exp_flag));
        chk({v.name, "_fail"},    256'(fail), 256'(v.exp_fail));
        chk({v.name, "_timeout"}, 256'(timeout), 256'(v.exp_to));
        chk({v.name, "_pass"},    256'(pass_count), 256'(v.exp_pass));
        exp_seg = v.exp_flag ? {7'h0C, 7'h08, 7'h12} : {7'h0E, 7'h08, 7'h79};
        chk({v.name, "_seg"},     256'(sevenSeg), 256'(exp_seg));
        repeat (3) @(negedge clk);
        chk({v.name, "_hold_flag"}, 256'(flag), 256'(v.exp_flag));
        chk({v.name, "_hold_busy"}, 256'(busy), 256'(0));
    endtask

    initial begin
        nr_tab[0] = 4'd10; nr_tab[1] = 4'd12; nr_tab[2] = 4'd14;
        key_tab[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        key_tab[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        key_tab[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ct_tab[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_tab[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct_tab[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

        //          mode  dly bad st done flag fail to  pass
        vecs[0] = '{2'd1,  5, 3, 1,  8, 1'b1, 1'b0, 1'b0, 2'd1, "m1_pass"};
        vecs[1] = '{2'd0,  5, 3, 3, 22, 1'b1, 1'b0, 1'b0, 2'd3, "sweep_pass"};
        vecs[2] = '{2'd3,  5, 2, 1,  8, 1'b0, 1'b1, 1'b0, 2'd0, "m3_flip"};
        vecs[3] = '{2'd0,  5, 1, 2, 15, 1'b0, 1'b1, 1'b0, 2'd1, "sweep_bad192"};
        vecs[4] = '{2'd2,  0, 3, 1, 66, 1'b0, 1'b1, 1'b1, 2'd0, "m2_timeout"};
        vecs[5] = '{2'd2, 64, 3, 1, 67, 1'b1, 1'b0, 1'b0, 2'd1, "m2_done_at_limit"};
        vecs[6] = '{2'd0,  1, 3, 3, 10, 1'b1, 1'b0, 1'b0, 2'd3, "sweep_fast"};
        vecs[7] = '{2'd2,  5, 3, 1,  8, 1'b1, 1'b0, 1'b0, 2'd1, "m2_pass"};

        reset = 1'b0; start = 1'b0; mode = 2'd0; core_done = 1'b0; core_out = 128'h0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b1;

        // spurious core_done in IDLE
        @(negedge clk);
        core_done = 1'b1; core_out = ct_tab[0];
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", 256'(busy), 256'(0));
        chk("idle_done_start", 256'(core_start), 256'(0));
        chk("idle_done_pass", 256'(pass_count), 256'(0));
        chk("idle_done_seg", 256'(sevenSeg), 256'(21'h1FFFFF));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

        // start/mode activity while busy must not disturb a mode-1 run
        vecs[0].name = "m1_noise";
        run_vec(vecs[0], 1'b1);

        // spurious bad core_done in DONE leaves results alone
        @(negedge clk);
        core_done = 1'b1; core_out = 128'h0;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        chk("done_spur_flag", 256'(flag), 256'(1));
        chk("done_spur_pass", 256'(pass_count), 256'(1));
        chk("done_spur_busy", 256'(busy), 256'(0));

        // reset in the middle of WAIT
        @(negedge clk);
        mode = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midwait_busy", 256'(busy), 256'(1));
        reset = 1'b0;
        @(negedge clk);
        check_reset("midwait_reset");
        reset = 1'b1;
        vecs[0].name = "after_reset";
        run_vec(vecs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
